// File: rtl/bus_arb_2m_pkg.sv
// Shared definitions for the two-master register-bus arbiter.
package bus_arb_2m_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_ACK     = 2'd3
  } arb_state_t;

  localparam int BUS_DW = 16;
  localparam logic [BUS_DW-1:0] RD_TIMEOUT_DATA = 16'h0000;

  // Index of the owning master from a one-hot grant.
  function automatic logic gnt_owner(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/bus_rr_pick2.sv
// Combinational two-way round-robin pick; ptr names the master favoured on a tie.
module bus_rr_pick2
  import bus_arb_2m_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/bus_arb_2m.sv
// Two-master round-robin sequencer: one CS strobe per transaction, read data
// or a timeout error returned to the master that owns the transaction.
module bus_arb_2m
  import bus_arb_2m_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_Bus_Rst_L,
  input  logic                  i_Bus_Clk,
  input  logic                  i_M0_Req,
  input  logic                  i_M0_Wr_Rd_n,
  input  logic [ADDR_WIDTH-1:0] i_M0_Addr8,
  input  logic [BUS_DW-1:0]     i_M0_Wr_Data,
  output logic                  o_M0_Ack,
  output logic                  o_M0_Err,
  output logic [BUS_DW-1:0]     o_M0_Rd_Data,
  input  logic                  i_M1_Req,
  input  logic                  i_M1_Wr_Rd_n,
  input  logic [ADDR_WIDTH-1:0] i_M1_Addr8,
  input  logic [BUS_DW-1:0]     i_M1_Wr_Data,
  output logic                  o_M1_Ack,
  output logic                  o_M1_Err,
  output logic [BUS_DW-1:0]     o_M1_Rd_Data,
  output logic                  o_Bus_CS,
  output logic                  o_Bus_Wr_Rd_n,
  output logic [ADDR_WIDTH-1:0] o_Bus_Addr8,
  output logic [BUS_DW-1:0]     o_Bus_Wr_Data,
  input  logic [BUS_DW-1:0]     i_Bus_Rd_Data,
  input  logic                  i_Bus_Rd_DV,
  output logic [1:0]            o_Grant
);

  typedef struct packed {
    logic                  wr_rd_n;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BUS_DW-1:0]     wr_data;
  } mreq_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t              state;
  logic                    ptr;
  logic [7:0]              tmo_cnt;
  logic [1:0]              req, pick, ack_q, err_q;
  logic [1:0][BUS_DW-1:0]  rd_q;
  mreq_t [1:0]             mreq;
  logic                    sel, owner;

  assign req     = {i_M1_Req, i_M0_Req};
  assign mreq[0] = {i_M0_Wr_Rd_n, i_M0_Addr8, i_M0_Wr_Data};
  assign mreq[1] = {i_M1_Wr_Rd_n, i_M1_Addr8, i_M1_Wr_Data};
  assign sel     = gnt_owner(pick);
  assign owner   = gnt_owner(o_Grant);

  bus_rr_pick2 u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick)
  );

  assign o_M0_Ack     = ack_q[0];
  assign o_M0_Err     = err_q[0];
  assign o_M0_Rd_Data = rd_q[0];
  assign o_M1_Ack     = ack_q[1];
  assign o_M1_Err     = err_q[1];
  assign o_M1_Rd_Data = rd_q[1];

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      state         <= ST_IDLE;
      ptr           <= 1'b0;
      tmo_cnt       <= '0;
      ack_q         <= '0;
      err_q         <= '0;
      rd_q          <= '0;
      o_Bus_CS      <= 1'b0;
      o_Bus_Wr_Rd_n <= 1'b0;
      o_Bus_Addr8   <= '0;
      o_Bus_Wr_Data <= '0;
      o_Grant       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            o_Bus_CS      <= 1'b1;
            o_Bus_Wr_Rd_n <= mreq[sel].wr_rd_n;
            o_Bus_Addr8   <= mreq[sel].addr;
            o_Bus_Wr_Data <= mreq[sel].wr_data;
            o_Grant       <= pick;
            // The master just served loses the next tie.
            ptr           <= ~sel;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          o_Bus_CS <= 1'b0;
          if (o_Bus_Wr_Rd_n) begin
            ack_q[owner] <= 1'b1;
            err_q[owner] <= 1'b0;
            state        <= ST_ACK;
          end else begin
            tmo_cnt <= '0;
            state   <= ST_WAIT_RD;
          end
        end
        ST_WAIT_RD: begin
          if (i_Bus_Rd_DV) begin
            rd_q[owner]  <= i_Bus_Rd_Data;
            ack_q[owner] <= 1'b1;
            err_q[owner] <= 1'b0;
            state        <= ST_ACK;
          end else if (tmo_cnt == TMO_LAST) begin
            rd_q[owner]  <= RD_TIMEOUT_DATA;
            ack_q[owner] <= 1'b1;
            err_q[owner] <= 1'b1;
            state        <= ST_ACK;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_ACK: begin
          ack_q   <= '0;
          err_q   <= '0;
          o_Grant <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_arb_2m.md
Name: bus_arb_2m

Overview:
- Two-master round-robin arbiter and sequencer for the 16-bit register bus.
- Takes transaction requests from two masters (e.g. UART command decoder and SPI command decoder) and issues each as a single-cycle CS strobe on the shared slave bus.
- Returns read data, or a timeout error, to the master that issued the request.
- Sits between the command front-ends and the bus register slaves.

Parameters:
- ADDR_WIDTH, 8, width of the byte address on the master and slave buses.
- TIMEOUT_CYCLES, 16, number of WAIT_RD cycles without i_Bus_Rd_DV before a read is errored; legal range 2..255.

Ports:
- i_Bus_Rst_L  in  1  reset, asynchronous, active-low.
- i_Bus_Clk  in  1  clock.
- i_M0_Req  in  1  master 0 request; held high with its fields stable until o_M0_Ack.
- i_M0_Wr_Rd_n  in  1  master 0 direction; 1 = write, 0 = read.
- i_M0_Addr8  in  ADDR_WIDTH  master 0 byte address.
- i_M0_Wr_Data  in  16  master 0 write data.
- o_M0_Ack  out  1  one-cycle completion pulse to master 0.
- o_M0_Err  out  1  valid with o_M0_Ack; 1 = read timed out.
- o_M0_Rd_Data  out  16  master 0 read result.
- i_M1_Req, i_M1_Wr_Rd_n, i_M1_Addr8, i_M1_Wr_Data, o_M1_Ack, o_M1_Err, o_M1_Rd_Data: same as master 0, for master 1.
- o_Bus_CS  out  1  slave chip select, one cycle per transaction.
- o_Bus_Wr_Rd_n  out  1  slave direction.
- o_Bus_Addr8  out  ADDR_WIDTH  slave address.
- o_Bus_Wr_Data  out  16  slave write data.
- i_Bus_Rd_Data  in  16  slave read data.
- i_Bus_Rd_DV  in  1  slave read data valid.
- o_Grant  out  2  one-hot owner of the current transaction; 00 when IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE, round-robin pointer = M0.
  - All outputs 0, including both Rd_Data buses.
  - A transaction in flight at reset is abandoned; the master receives no Ack.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_RD, ACK.
- IDLE:
  - If any Req is high, select a master.
  - Only one requesting: select it.
  - Both requesting: select the pointer master.
  - Latch the selected master's Wr_Rd_n, Addr8 and Wr_Data onto the o_Bus_* outputs, set o_Bus_CS=1, set o_Grant, toggle the pointer to the other master, and go to ISSUE.
- ISSUE:
  - CS is high for exactly this cycle; clear CS on exit.
  - Write: set Ack=1 and Err=0 for the owner, then go to ACK.
  - Read: clear the timeout counter and go to WAIT_RD.
- WAIT_RD:
  - If i_Bus_Rd_DV=1: capture i_Bus_Rd_Data into the owner's Rd_Data, set Ack=1 and Err=0, go to ACK.
  - Else if counter == TIMEOUT_CYCLES-1: set owner Rd_Data=0x0000, Ack=1, Err=1, go to ACK.
  - Else increment the counter.
- ACK:
  - Ack and Err are high for exactly this cycle.
  - On exit, clear Ack, Err and o_Grant, and go to IDLE.
  - The master must drop Req at the edge that samples Ack=1, so IDLE never re-grants a completed request.
- Latency from the first Req-high cycle (cycle 0):
  - Write: CS in cycle 1, Ack in cycle 2.
  - Read with a registered slave: CS in cycle 1, DV in cycle 2, Ack with data in cycle 3.
  - Read timeout: Ack in cycle 2+TIMEOUT_CYCLES.
- Throughput: one transaction per ACK→IDLE round trip, minimum 3 cycles per write. With both masters requesting continuously, grants alternate strictly.
- i_Bus_Rd_DV outside WAIT_RD is ignored. This includes a late DV arriving after a timeout.
- Rd_Data of the non-owning master is never modified. Rd_Data holds its value until that master's next read completes.
- A Req change while not in IDLE has no effect until IDLE.
- The timeout counter is 8 bits.

Decomposition:
- Shared bus package holds:
  - state encodings (IDLE=0, ISSUE=1, WAIT_RD=2, ACK=3);
  - the timeout read value 16'h0000;
  - the bus data width constant 16.
- One sub-module: bus_rr_pick2.
  - Combinational picker: inputs two Reqs and the pointer; output one-hot grant.
  - The pointer register stays in bus_arb_2m.

Test Plan:
- M0 write, Addr8=0x02, data 0x1234 → cycle 1: CS=1, Wr_Rd_n=1, Addr8=0x02, Wr_Data=0x1234. Cycle 2: o_M0_Ack=1, o_M0_Err=0. o_M1_Ack stays 0 throughout.
- M1 read, Addr8=0x00, slave model returns 0xBEEF with DV one cycle after CS → o_M1_Ack in cycle 3, o_M1_Rd_Data=0xBEEF, o_M0_Rd_Data unchanged at 0x0000.
- Both Reqs held high from reset, fields re-presented after each Ack, 4 transactions → grant order M0, M1, M0, M1. Exactly one CS per transaction.
- M0 read with no DV, TIMEOUT_CYCLES=16 → o_M0_Ack and o_M0_Err high in cycle 18, o_M0_Rd_Data=0x0000. A DV injected in cycle 19 is ignored, and the next M1 write completes normally.
- Reset asserted mid-WAIT_RD → CS, Ack and Grant go low immediately, no Ack is produced. After release, an M1 write Req is granted first (pointer back at M0, M0 idle) and completes in 2 cycles.
- Stray i_Bus_Rd_DV=1 with data 0xAAAA in IDLE and during a write's ISSUE → no Ack, and neither Rd_Data changes.
